// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// mem_stage_lsu : MEM-stage load/store unit (valid/ready data bus, load extend)
// Revision      : 1.0
// ============================================================================
module mem_stage_lsu (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_read_MEM,
  input  logic        i_mem_write_MEM,
  input  logic [2:0]  i_funct3_MEM,
  input  logic [31:0] i_alu_result_MEM,
  input  logic [31:0] i_write_data_MEM,
  input  logic        i_reg_write_MEM,
  output logic [31:0] o_data_MEM,
  output logic        o_reg_write_MEM,
  output logic        o_stall_MEM,
  output logic        o_fault_MEM,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t      r_state;
  logic [29:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_data;
  logic [3:0]  r_be;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic        r_reg_write;

  logic        w_mem;
  logic        w_legal;
  logic        w_aligned;
  logic        w_access;
  logic        w_fault;
  logic [1:0]  w_lo;
  logic [31:0] w_wdata;
  logic [3:0]  w_be;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_mem    = i_mem_read_MEM | i_mem_write_MEM;
  assign w_lo     = i_alu_result_MEM[1:0];
  assign w_legal  = i_funct3_MEM inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
  assign w_access = w_mem & w_legal & w_aligned;
  assign w_fault  = w_mem & ~(w_legal & w_aligned);

  always_comb begin
    w_aligned = 1'b1;
    w_wdata   = i_write_data_MEM;
    w_be      = 4'b1111;
    case (i_funct3_MEM[1:0])
      2'b00: begin
        w_wdata = {4{i_write_data_MEM[7:0]}};
        w_be    = 4'b0001 << w_lo;
      end
      2'b01: begin
        w_aligned = ~w_lo[0];
        w_wdata   = {2{i_write_data_MEM[15:0]}};
        w_be      = w_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: w_aligned = (w_lo == 2'b00);
    endcase
  end

  // Load extraction works from the latched lane/size, not the live EX/MEM inputs.
  always_comb begin
    w_byte      = 8'(i_dmem_rdata >> {r_lane, 3'b000});
    w_half      = r_lane[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    w_load_data = i_dmem_rdata;
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = i_dmem_rdata;
    endcase
  end

  // A granted store completes in its grant cycle, so it releases the pipeline there.
  always_comb begin
    o_dmem_req   = 1'b0;
    o_dmem_we    = 1'b0;
    o_dmem_addr  = 32'd0;
    o_dmem_wdata = 32'd0;
    o_dmem_be    = 4'd0;
    o_stall_MEM  = 1'b0;
    if (i_rst_n) begin
      case (r_state)
        IDLE: if (w_access) begin
          o_dmem_req   = 1'b1;
          o_dmem_we    = i_mem_write_MEM;
          o_dmem_addr  = {i_alu_result_MEM[31:2], 2'b00};
          o_dmem_wdata = w_wdata;
          o_dmem_be    = w_be;
          o_stall_MEM  = ~i_mem_write_MEM | ~i_dmem_gnt;
        end
        REQ: begin
          o_dmem_req   = 1'b1;
          o_dmem_we    = r_we;
          o_dmem_addr  = {r_addr, 2'b00};
          o_dmem_wdata = r_wdata;
          o_dmem_be    = r_be;
          o_stall_MEM  = ~(r_we & i_dmem_gnt);
        end
        WAIT:    o_stall_MEM = 1'b1;
        default: o_stall_MEM = 1'b0;
      endcase
    end
  end

  assign o_fault_MEM     = i_rst_n & w_fault;
  assign o_reg_write_MEM = i_rst_n & ~o_stall_MEM & ~w_fault &
                           ((r_state == DONE) ? r_reg_write : i_reg_write_MEM);
  assign o_data_MEM      = r_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_addr      <= 30'd0;
      r_wdata     <= 32'd0;
      r_data      <= 32'd0;
      r_be        <= 4'd0;
      r_we        <= 1'b0;
      r_funct3    <= 3'd0;
      r_lane      <= 2'd0;
      r_reg_write <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_access) begin
          r_addr      <= i_alu_result_MEM[31:2];
          r_wdata     <= w_wdata;
          r_be        <= w_be;
          r_we        <= i_mem_write_MEM;
          r_funct3    <= i_funct3_MEM;
          r_lane      <= w_lo;
          r_reg_write <= i_reg_write_MEM;
          if (i_dmem_gnt) r_state <= i_mem_write_MEM ? IDLE : WAIT;
          else            r_state <= REQ;
        end
        REQ: if (i_dmem_gnt) r_state <= r_we ? IDLE : WAIT;
        WAIT: if (i_dmem_rvalid) begin
          r_data  <= w_load_data;
          r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// tb_mem_stage_lsu : directed + randomized scoreboard bench for mem_stage_lsu
// Revision         : 1.0
// ============================================================================
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0, reg_write = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0, wdata = 32'd0;

  logic [31:0] data_o, daddr_o, dwdata_o;
  logic        rw_o, stall_o, fault_o, req_o, we_o;
  logic [3:0]  be_o;

  logic        auto_mem = 1'b0, sb_en = 1'b0, inst_active = 1'b0;
  logic        m_gnt = 1'b0, m_rvalid = 1'b0, a_gnt = 1'b0, a_rvalid = 1'b0;
  logic [31:0] m_rdata = 32'd0, a_rdata = 32'd0;
  logic        gnt, rvalid;
  logic [31:0] rdata;

  assign gnt    = auto_mem ? a_gnt    : m_gnt;
  assign rvalid = auto_mem ? a_rvalid : m_rvalid;
  assign rdata  = auto_mem ? a_rdata  : m_rdata;

  mem_stage_lsu dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_mem_read_MEM(mem_read), .i_mem_write_MEM(mem_write),
    .i_funct3_MEM(funct3), .i_alu_result_MEM(addr),
    .i_write_data_MEM(wdata), .i_reg_write_MEM(reg_write),
    .o_data_MEM(data_o), .o_reg_write_MEM(rw_o), .o_stall_MEM(stall_o),
    .o_fault_MEM(fault_o), .o_dmem_req(req_o), .o_dmem_we(we_o),
    .o_dmem_addr(daddr_o), .o_dmem_wdata(dwdata_o), .o_dmem_be(be_o),
    .i_dmem_gnt(gnt), .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata)
  );

  initial forever #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] be; } bus_t;
  typedef struct { logic rw; logic fault; logic chkd; logic [31:0] data; } wb_t;
  bus_t bus_q[$];
  wb_t  wb_q[$];

  // Reference memory (bytes) and the bus-side memory (words) cover 0x100..0x13F.
  logic [7:0]  ref_mem[64];
  logic [31:0] env_mem[16];

  // Bus-side memory responder used in randomized mode.
  initial begin : responder
    logic        s_fire, s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;
    logic        pend;
    int          pdly;
    logic [31:0] pdata;
    pend = 1'b0; pdly = 0; pdata = 32'd0;
    forever begin
      @(negedge clk);
      s_fire = auto_mem & req_o & gnt;
      s_we = we_o; s_addr = daddr_o; s_wdata = dwdata_o; s_be = be_o;
      @(posedge clk);
      #2;
      a_rvalid = 1'b0;
      a_rdata  = $urandom;
      if (!rst_n || !auto_mem) begin
        pend  = 1'b0;
        a_gnt = 1'b0;
      end else begin
        if (s_fire) begin
          if (s_we) begin
            for (int k = 0; k < 4; k++)
              if (s_be[k]) env_mem[(s_addr - 32'h100) >> 2][8*k +: 8] = s_wdata[8*k +: 8];
          end else begin
            pend  = 1'b1;
            pdly  = $urandom_range(0, 3);
            pdata = env_mem[(s_addr - 32'h100) >> 2];
          end
        end
        if (pend) begin
          if (pdly == 0) begin
            a_rvalid = 1'b1;
            a_rdata  = pdata;
            pend     = 1'b0;
          end else pdly--;
        end
        a_gnt = ($urandom_range(0, 9) < 6);
      end
    end
  end

  // Scoreboard monitor: bus handshakes and instruction retirement.
  initial begin : monitor
    bus_t b;
    wb_t  w;
    forever begin
      @(negedge clk);
      if (sb_en && rst_n) begin
        if (req_o && gnt) begin
          if (bus_q.size() == 0) check("bus_unexpected_req", {31'd0, req_o}, 32'd0);
          else begin
            b = bus_q.pop_front();
            check("bus_we", {31'd0, we_o}, {31'd0, b.we});
            check("bus_addr", daddr_o, b.addr);
            if (b.we) begin
              check("bus_wdata", dwdata_o, b.wdata);
              check("bus_be", {28'd0, be_o}, {28'd0, b.be});
            end
          end
        end
        if (inst_active && !stall_o) begin
          if (wb_q.size() == 0) check("wb_unexpected_retire", {31'd0, !stall_o}, 32'd0);
          else begin
            w = wb_q.pop_front();
            check("wb_reg_write", {31'd0, rw_o}, {31'd0, w.rw});
            check("wb_fault", {31'd0, fault_o}, {31'd0, w.fault});
            if (w.chkd) check("wb_load_data", data_o, w.data);
          end
        end
      end
    end
  end

  task automatic set_inst(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic rw);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd; reg_write = rw;
  endtask

  task automatic dir_load(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rd, input logic [31:0] exp);
    @(posedge clk); #1;
    set_inst(1, 0, f3, a, 32'd0, 1); m_gnt = 1'b1;
    @(negedge clk);
    check({nm, "_c0_stall"}, {31'd0, stall_o}, 32'd1);
    check({nm, "_c0_addr"}, daddr_o, {a[31:2], 2'b00});
    @(posedge clk); #1;
    m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = rd;
    @(negedge clk);
    check({nm, "_c1_stall"}, {31'd0, stall_o}, 32'd1);
    @(posedge clk); #1;
    m_rvalid = 1'b0; m_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    check({nm, "_c2_stall"}, {31'd0, stall_o}, 32'd0);
    check({nm, "_c2_req"}, {31'd0, req_o}, 32'd0);
    check({nm, "_c2_data"}, data_o, exp);
    check({nm, "_c2_rw"}, {31'd0, rw_o}, 32'd1);
    @(posedge clk); #1;
    set_inst(0, 0, 3'd0, 32'd0, 32'd0, 0);
  endtask

  task automatic rand_inst();
    int kind, n, off, waits;
    logic rd, wr, rw, legal;
    logic [2:0] f3;
    logic [31:0] wd, val;
    bus_t b;
    wb_t w;
    kind = $urandom_range(0, 9);
    rd = (kind >= 2 && kind <= 5) || kind == 9;
    wr = (kind >= 6);
    rw = ($urandom_range(0, 3) != 0);
    wd = $urandom;
    legal = ($urandom_range(0, 99) < 85);
    if (!legal)  f3 = (kind % 3 == 0) ? 3'd3 : ((kind % 3 == 1) ? 3'd6 : 3'd7);
    else if (wr) f3 = 3'($urandom_range(0, 2));
    else begin
      case ($urandom_range(0, 4))
        0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
      endcase
    end
    case (f3)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      default:    n = 4;
    endcase
    off = $urandom_range(0, 63);
    if (legal && $urandom_range(0, 9) < 8) off = off - (off % n);
    if (off + n > 64) off = 64 - n;

    w.rw = rw; w.fault = 1'b0; w.chkd = 1'b0; w.data = 32'd0;
    if ((rd || wr) && (!legal || (off % n) != 0)) begin
      w.rw = 1'b0; w.fault = 1'b1;
    end else if (wr) begin
      b.we = 1'b1; b.addr = 32'h100 + 32'(off - off % 4);
      for (int k = 0; k < 4; k++) begin
        b.wdata[8*k +: 8] = 8'(wd >> (8 * (k % n)));
        b.be[k] = (k >= off % 4) && (k < off % 4 + n);
      end
      bus_q.push_back(b);
      for (int i = 0; i < n; i++) ref_mem[off + i] = 8'(wd >> (8 * i));
    end else if (rd) begin
      b.we = 1'b0; b.addr = 32'h100 + 32'(off - off % 4); b.wdata = 32'd0; b.be = 4'd0;
      bus_q.push_back(b);
      val = 32'd0;
      for (int i = 0; i < n; i++) val = val | (32'(ref_mem[off + i]) << (8 * i));
      if (f3 == 3'd0 && val[7])  val = val | 32'hFFFFFF00;
      if (f3 == 3'd1 && val[15]) val = val | 32'hFFFF0000;
      w.chkd = 1'b1; w.data = val;
    end
    wb_q.push_back(w);

    @(posedge clk); #1;
    set_inst(rd, wr, f3, 32'h100 + 32'(off), wd, rw);
    inst_active = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (!stall_o) break;
      waits++;
      if (waits > 40) begin
        check("retire_timeout", {31'd0, stall_o}, 32'd0);
        break;
      end
    end
  endtask

  initial begin : stim
    logic [31:0] v;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      env_mem[i] = v;
      for (int k = 0; k < 4; k++) ref_mem[4*i + k] = v[8*k +: 8];
    end

    // Reset holds every output quiet even with a load (and a misaligned one) present.
    set_inst(1, 0, 3'd2, 32'h100, 32'd0, 1); m_gnt = 1'b1;
    @(negedge clk);
    check("rst_req", {31'd0, req_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_rw", {31'd0, rw_o}, 32'd0);
    check("rst_data", data_o, 32'd0);
    addr = 32'h102;
    #1 check("rst_fault", {31'd0, fault_o}, 32'd0);
    @(negedge clk);
    set_inst(0, 0, 3'd0, 32'd0, 32'd0, 0); m_gnt = 1'b0;
    rst_n = 1'b1;

    dir_load("lw",  3'd2, 32'h100, 32'hDEADBEEF, 32'hDEADBEEF);
    dir_load("lb",  3'd0, 32'h103, 32'h80112233, 32'hFFFFFF80);
    dir_load("lbu", 3'd4, 32'h103, 32'h80112233, 32'h00000080);
    dir_load("lh",  3'd1, 32'h102, 32'h80112233, 32'hFFFF8011);

    // sh with grant held off for three cycles.
    @(posedge clk); #1;
    set_inst(0, 1, 3'd1, 32'h106, 32'h0000ABCD, 0); m_gnt = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) m_gnt = 1'b1;
      @(negedge clk);
      check("sh_req", {31'd0, req_o}, 32'd1);
      check("sh_addr", daddr_o, 32'h104);
      check("sh_wdata", dwdata_o, 32'hABCDABCD);
      check("sh_be", {28'd0, be_o}, 32'hC);
      check("sh_stall", {31'd0, stall_o}, (c < 3) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    set_inst(0, 0, 3'd0, 32'd0, 32'd0, 0); m_gnt = 1'b1;
    @(negedge clk);
    check("sh_after_req", {31'd0, req_o}, 32'd0);
    check("sh_after_stall", {31'd0, stall_o}, 32'd0);

    // Faults: misaligned lw, reserved funct3.
    for (int t = 0; t < 2; t++) begin
      @(posedge clk); #1;
      if (t == 0) set_inst(1, 0, 3'd2, 32'h102, 32'd0, 1);
      else        set_inst(1, 0, 3'd3, 32'h100, 32'd0, 1);
      @(negedge clk);
      check("flt_fault", {31'd0, fault_o}, 32'd1);
      check("flt_req", {31'd0, req_o}, 32'd0);
      check("flt_stall", {31'd0, stall_o}, 32'd0);
      check("flt_rw", {31'd0, rw_o}, 32'd0);
    end

    // Reset during WAIT, then a stray rvalid.
    @(posedge clk); #1;
    set_inst(1, 0, 3'd2, 32'h100, 32'd0, 1); m_gnt = 1'b1;
    @(posedge clk); #1;
    m_gnt = 1'b0;
    @(negedge clk);
    check("wait_stall", {31'd0, stall_o}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_stall", {31'd0, stall_o}, 32'd0);
    check("arst_req", {31'd0, req_o}, 32'd0);
    check("arst_data", data_o, 32'd0);
    set_inst(0, 0, 3'd0, 32'd0, 32'd0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    m_rvalid = 1'b1; m_rdata = 32'h12345678;
    @(negedge clk);
    check("stray_stall", {31'd0, stall_o}, 32'd0);
    @(posedge clk); #1;
    m_rvalid = 1'b0;
    @(negedge clk);
    check("stray_data", data_o, 32'd0);

    // Non-memory instruction.
    @(posedge clk); #1;
    set_inst(0, 0, 3'd0, 32'h100, 32'd0, 1); m_gnt = 1'b1;
    @(negedge clk);
    check("alu_req", {31'd0, req_o}, 32'd0);
    check("alu_stall", {31'd0, stall_o}, 32'd0);
    check("alu_rw", {31'd0, rw_o}, 32'd1);

    // Randomized traffic against the byte-level reference model.
    @(posedge clk); #1;
    m_gnt = 1'b0;
    set_inst(0, 0, 3'd0, 32'd0, 32'd0, 0);
    auto_mem = 1'b1; sb_en = 1'b1;
    for (int i = 0; i < 300; i++) rand_inst();
    @(posedge clk); #1;
    inst_active = 1'b0;
    set_inst(0, 0, 3'd0, 32'd0, 32'd0, 0);
    repeat (5) @(negedge clk);
    check("bus_q_drained", bus_q.size(), 32'd0);
    check("wb_q_drained", wb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
